// File: rtl/rx_serial_32_paridade_pkg.sv
// Constants shared by the serial receiver and interface_dht11: default clock
// and line rate, the derived bit timings, and the parity-check helper.
package rx_serial_32_paridade_pkg;

    localparam int CLK_FREQ_PADRAO = 50_000_000;
    localparam int BAUD_PADRAO     = 9600;
    localparam int CLKS_BIT_PADRAO = CLK_FREQ_PADRAO / BAUD_PADRAO;
    localparam int MEIO_BIT_PADRAO = CLKS_BIT_PADRAO / 2;

    // xor_total is the XOR of data and parity bit; it must equal 1 for odd
    // parity and 0 for even parity, anything else is a parity error.
    function automatic logic calc_erro_paridade(input logic xor_total, input logic impar);
        return xor_total ^ impar;
    endfunction

endpackage

// File: rtl/rx_serial_32_paridade_contador_baud.sv
// Loadable down-counter used to time half-bit and full-bit intervals.
// fim is high while the count sits at zero; the FSM reloads on that cycle,
// so in practice it acts as a one-cycle terminal pulse.
module contador_baud #(
    parameter int LARGURA = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpa,
    input  logic               carrega,
    input  logic [LARGURA-1:0] valor,
    output logic               fim
);

    logic [LARGURA-1:0] conta_q, conta_d;

    // Next count: clear wins over load, otherwise count down and park at zero.
    always_comb begin
        conta_d = conta_q;
        if (limpa) begin
            conta_d = '0;
        end else if (carrega) begin
            conta_d = valor;
        end else if (conta_q != '0) begin
            conta_d = conta_q - LARGURA'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conta_q <= '0;
        end else begin
            conta_q <= conta_d;
        end
    end

    assign fim = (conta_q == '0);

endmodule

// File: rtl/rx_serial_32_paridade.sv
// Async serial receiver: start, N_DADOS data bits LSB first, parity, stop.
// Bits are sampled at mid-bit; the word and error flags are updated together
// with a one-cycle pronto pulse at the end of every completed frame.
module rx_serial_32_paridade
    import rx_serial_32_paridade_pkg::*;
#(
    parameter int CLK_FREQ       = CLK_FREQ_PADRAO,
    parameter int BAUD           = BAUD_PADRAO,
    parameter int N_DADOS        = 32,
    parameter bit PARIDADE_IMPAR = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rx_serial,
    output logic [N_DADOS-1:0] dado_recebido,
    output logic               pronto,
    output logic               erro_paridade,
    output logic               erro_stop,
    output logic [3:0]         db_estado
);

    localparam int CLKS_BIT = CLK_FREQ / BAUD;
    localparam int MEIO_BIT = CLKS_BIT / 2;
    localparam int CW       = $clog2(CLKS_BIT);
    localparam int IW       = $clog2(N_DADOS + 2);

    // The counter is loaded on the transition into a waiting state and that
    // state is left on the cycle the count reaches zero, so a load of N-2
    // keeps the FSM in the state for N-1 cycles.
    localparam logic [CW-1:0] CARGA_MEIO = CW'(MEIO_BIT - 2);
    localparam logic [CW-1:0] CARGA_BIT  = CW'(CLKS_BIT - 2);
    localparam logic [IW-1:0] IDX_PAR    = IW'(N_DADOS);
    localparam logic [IW-1:0] IDX_STOP   = IW'(N_DADOS + 1);

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        ESPERA_START = 4'd1,
        ESPERA_BIT   = 4'd2,
        AMOSTRA      = 4'd3,
        FINAL        = 4'd4
    } estado_t;

    estado_t            estado_q, estado_d;
    logic               sync1_q, sync2_q, ant_q;
    logic               borda_descida;
    logic [IW-1:0]      indice_q, indice_d;
    logic [N_DADOS-1:0] dados_q, dados_d;
    logic               par_q, par_d;
    logic               stop_q, stop_d;
    logic [N_DADOS-1:0] saida_q, saida_d;
    logic               erro_par_q, erro_par_d;
    logic               erro_stop_q, erro_stop_d;
    logic               cont_limpa, cont_carrega, cont_fim;
    logic [CW-1:0]      cont_valor;

    // Two-flop synchronizer plus previous-value flop for edge detection;
    // all reset to the idle level so a line held low gives one edge only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            ant_q   <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
            ant_q   <= sync2_q;
        end
    end

    assign borda_descida = ant_q & ~sync2_q;

    contador_baud #(
        .LARGURA (CW)
    ) u_contador (
        .clock   (clock),
        .reset   (reset),
        .limpa   (cont_limpa),
        .carrega (cont_carrega),
        .valor   (cont_valor),
        .fim     (cont_fim)
    );

    // Next-state, datapath and counter control for the frame FSM.
    always_comb begin
        estado_d     = estado_q;
        indice_d     = indice_q;
        dados_d      = dados_q;
        par_d        = par_q;
        stop_d       = stop_q;
        saida_d      = saida_q;
        erro_par_d   = erro_par_q;
        erro_stop_d  = erro_stop_q;
        cont_limpa   = 1'b0;
        cont_carrega = 1'b0;
        cont_valor   = CARGA_BIT;
        case (estado_q)
            INICIAL: begin
                if (borda_descida) begin
                    estado_d     = ESPERA_START;
                    cont_carrega = 1'b1;
                    cont_valor   = CARGA_MEIO;
                end else begin
                    cont_limpa   = 1'b1;
                end
            end
            ESPERA_START: begin
                if (cont_fim) begin
                    if (!sync2_q) begin
                        estado_d     = ESPERA_BIT;
                        indice_d     = '0;
                        cont_carrega = 1'b1;
                    end else begin
                        estado_d     = INICIAL;
                    end
                end
            end
            ESPERA_BIT: begin
                if (cont_fim) begin
                    estado_d = AMOSTRA;
                end
            end
            AMOSTRA: begin
                if (indice_q < IDX_PAR) begin
                    dados_d = {sync2_q, dados_q[N_DADOS-1:1]};
                end else if (indice_q == IDX_PAR) begin
                    par_d   = sync2_q;
                end else begin
                    stop_d  = sync2_q;
                end
                indice_d = indice_q + IW'(1);
                if (indice_q == IDX_STOP) begin
                    estado_d     = FINAL;
                end else begin
                    estado_d     = ESPERA_BIT;
                    cont_carrega = 1'b1;
                end
            end
            FINAL: begin
                saida_d     = dados_q;
                erro_par_d  = calc_erro_paridade(^{dados_q, par_q}, PARIDADE_IMPAR);
                erro_stop_d = ~stop_q;
                // A start edge landing right here would be lost in INICIAL,
                // so accept it directly to allow back-to-back frames.
                if (borda_descida) begin
                    estado_d     = ESPERA_START;
                    cont_carrega = 1'b1;
                    cont_valor   = CARGA_MEIO;
                end else begin
                    estado_d     = INICIAL;
                end
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    // State, shift register and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= INICIAL;
            indice_q    <= '0;
            dados_q     <= '0;
            par_q       <= 1'b0;
            stop_q      <= 1'b1;
            saida_q     <= '0;
            erro_par_q  <= 1'b0;
            erro_stop_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            indice_q    <= indice_d;
            dados_q     <= dados_d;
            par_q       <= par_d;
            stop_q      <= stop_d;
            saida_q     <= saida_d;
            erro_par_q  <= erro_par_d;
            erro_stop_q <= erro_stop_d;
        end
    end

    assign dado_recebido = saida_q;
    assign erro_paridade = erro_par_q;
    assign erro_stop     = erro_stop_q;
    assign pronto        = (estado_q == FINAL);
    assign db_estado     = estado_q;

endmodule

// File: tb/tb_rx_serial_32_paridade.sv
// Directed bench for rx_serial_32_paridade. Line rate is scaled down to
// 100 clk/bit so the whole run stays short; the sender uses 101 clk/bit to
// exercise the +1% drift tolerance.
module tb_rx_serial_32_paridade;

    localparam int TB_CLK_FREQ = 1_000_000;
    localparam int TB_BAUD     = 10_000;
    localparam int BIT_TB      = 101;

    logic        clock;
    logic        reset;
    logic        rx_serial;
    logic [31:0] dado_recebido;
    logic        pronto;
    logic        erro_paridade;
    logic        erro_stop;
    logic [3:0]  db_estado;

    rx_serial_32_paridade #(
        .CLK_FREQ       (TB_CLK_FREQ),
        .BAUD           (TB_BAUD),
        .N_DADOS        (32),
        .PARIDADE_IMPAR (1'b1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_serial     (rx_serial),
        .dado_recebido (dado_recebido),
        .pronto        (pronto),
        .erro_paridade (erro_paridade),
        .erro_stop     (erro_stop),
        .db_estado     (db_estado)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    typedef struct packed {
        logic [31:0] word;
        logic        par;
        logic        stop;
        logic [31:0] exp_word;
        logic        exp_perr;
        logic        exp_serr;
    } vec_t;

    vec_t tabela [7];

    int n_vec  = 0;
    int n_miss = 0;

    // Monitor: counts cycles with pronto high and captures the outputs on
    // the cycle after each pulse.
    int          pronto_cnt = 0;
    int          cap_n      = 0;
    logic        pronto_dly = 1'b0;
    logic [31:0] cap_word [16];
    logic        cap_perr [16];
    logic        cap_serr [16];

    always @(negedge clock) begin
        if (pronto_dly && cap_n < 16) begin
            cap_word[cap_n] = dado_recebido;
            cap_perr[cap_n] = erro_paridade;
            cap_serr[cap_n] = erro_stop;
            cap_n++;
        end
        pronto_dly = pronto;
        if (pronto) pronto_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic idle(input int ciclos);
        rx_serial = 1'b1;
        repeat (ciclos) @(negedge clock);
    endtask

    // Sends one frame; rst_bit >= 0 pulses reset for 2 clk at the start of
    // that data bit while the rest of the frame keeps going out.
    task automatic send_frame(input logic [31:0] w, input logic p, input logic s, input int rst_bit);
        rx_serial = 1'b0;
        repeat (BIT_TB) @(negedge clock);
        for (int i = 0; i < 32; i++) begin
            rx_serial = w[i];
            if (i == rst_bit) begin
                reset = 1'b1;
                repeat (2) @(negedge clock);
                reset = 1'b0;
                repeat (BIT_TB - 2) @(negedge clock);
            end else begin
                repeat (BIT_TB) @(negedge clock);
            end
        end
        rx_serial = p;
        repeat (BIT_TB) @(negedge clock);
        rx_serial = s;
        repeat (BIT_TB) @(negedge clock);
        rx_serial = 1'b1;
    endtask

    initial begin
        int          c0;
        int          b0;
        logic [31:0] w0, w1;
        logic        pe0, se0, pe1, se1;

        //               word          par   stop  exp_word      perr  serr
        tabela[0] = '{32'hAAAABBBB, 1'b1, 1'b1, 32'hAAAABBBB, 1'b0, 1'b0};
        tabela[1] = '{32'hAAAABBBB, 1'b0, 1'b1, 32'hAAAABBBB, 1'b1, 1'b0};
        tabela[2] = '{32'h12345678, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b1};
        tabela[3] = '{32'h0000FFFF, 1'b1, 1'b1, 32'h0000FFFF, 1'b0, 1'b0};
        tabela[4] = '{32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0};
        tabela[5] = '{32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        tabela[6] = '{32'h80000001, 1'b1, 1'b1, 32'h80000001, 1'b0, 1'b0};

        reset     = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(negedge clock);
        check("reset dado_recebido", dado_recebido, 32'h0);
        check("reset pronto", {31'b0, pronto}, 32'h0);
        check("reset erro_paridade", {31'b0, erro_paridade}, 32'h0);
        check("reset erro_stop", {31'b0, erro_stop}, 32'h0);
        check("reset db_estado", {28'b0, db_estado}, 32'h0);
        reset = 1'b0;
        idle(2 * BIT_TB);

        // Table-driven frames.
        for (int v = 0; v < 7; v++) begin
            c0 = pronto_cnt;
            send_frame(tabela[v].word, tabela[v].par, tabela[v].stop, -1);
            idle(2 * BIT_TB);
            $display("frame %0d: sent %h par=%b stop=%b -> dado=%h perr=%b serr=%b pulses=%0d",
                     v, tabela[v].word, tabela[v].par, tabela[v].stop,
                     dado_recebido, erro_paridade, erro_stop, pronto_cnt - c0);
            check($sformatf("frame%0d pronto pulses", v), pronto_cnt - c0, 32'd1);
            check($sformatf("frame%0d dado_recebido", v), dado_recebido, tabela[v].exp_word);
            check($sformatf("frame%0d erro_paridade", v), {31'b0, erro_paridade}, {31'b0, tabela[v].exp_perr});
            check($sformatf("frame%0d erro_stop", v), {31'b0, erro_stop}, {31'b0, tabela[v].exp_serr});
        end

        // Short low glitch on an idle line: start detected, then rejected.
        c0 = pronto_cnt;
        rx_serial = 1'b0;
        repeat (20) @(negedge clock);
        check("glitch db_estado during", {28'b0, db_estado}, 32'd1);
        idle(150);
        $display("glitch: state=%0d dado=%h pulses=%0d", db_estado, dado_recebido, pronto_cnt - c0);
        check("glitch db_estado after", {28'b0, db_estado}, 32'd0);
        check("glitch pronto pulses", pronto_cnt - c0, 32'd0);
        check("glitch dado_recebido", dado_recebido, 32'h80000001);
        check("glitch erro_paridade", {31'b0, erro_paridade}, 32'h0);

        // Load an error flag, then abort a frame with reset mid-way.
        send_frame(32'h00000000, 1'b0, 1'b1, -1);
        idle(2 * BIT_TB);
        check("pre-reset erro_paridade", {31'b0, erro_paridade}, 32'h1);
        c0 = pronto_cnt;
        send_frame(32'hFFFFFFFF, 1'b1, 1'b1, 10);
        idle(2 * BIT_TB);
        $display("reset abort: dado=%h perr=%b serr=%b state=%0d pulses=%0d",
                 dado_recebido, erro_paridade, erro_stop, db_estado, pronto_cnt - c0);
        check("abort pronto pulses", pronto_cnt - c0, 32'd0);
        check("abort dado_recebido", dado_recebido, 32'h0);
        check("abort erro_paridade", {31'b0, erro_paridade}, 32'h0);
        check("abort erro_stop", {31'b0, erro_stop}, 32'h0);
        check("abort db_estado", {28'b0, db_estado}, 32'd0);

        c0 = pronto_cnt;
        send_frame(32'h00000001, 1'b0, 1'b1, -1);
        idle(2 * BIT_TB);
        $display("after reset: dado=%h perr=%b pulses=%0d", dado_recebido, erro_paridade, pronto_cnt - c0);
        check("post-reset pronto pulses", pronto_cnt - c0, 32'd1);
        check("post-reset dado_recebido", dado_recebido, 32'h00000001);
        check("post-reset erro_paridade", {31'b0, erro_paridade}, 32'h0);

        // Back-to-back frames with no idle gap after the first stop bit.
        c0 = pronto_cnt;
        b0 = cap_n;
        send_frame(32'h12345678, 1'b0, 1'b1, -1);
        send_frame(32'hFFFF0000, 1'b1, 1'b1, -1);
        idle(2 * BIT_TB);
        w0 = 32'hDEADDEAD; pe0 = 1'bx; se0 = 1'bx;
        w1 = 32'hDEADDEAD; pe1 = 1'bx; se1 = 1'bx;
        if (cap_n >= b0 + 1 && b0 < 16) begin
            w0 = cap_word[b0]; pe0 = cap_perr[b0]; se0 = cap_serr[b0];
        end
        if (cap_n >= b0 + 2 && b0 + 1 < 16) begin
            w1 = cap_word[b0+1]; pe1 = cap_perr[b0+1]; se1 = cap_serr[b0+1];
        end
        $display("back-to-back: pulses=%0d w0=%h w1=%h", pronto_cnt - c0, w0, w1);
        check("b2b pronto pulses", pronto_cnt - c0, 32'd2);
        check("b2b first word", w0, 32'h12345678);
        check("b2b first erro_paridade", {31'b0, pe0}, 32'h0);
        check("b2b first erro_stop", {31'b0, se0}, 32'h0);
        check("b2b second word", w1, 32'hFFFF0000);
        check("b2b second erro_paridade", {31'b0, pe1}, 32'h0);
        check("b2b second erro_stop", {31'b0, se1}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
